// File: rtl/bcd_hex_display_if.sv
// rtl/bcd_hex_display_if.sv - start/busy/done handshake and HEX segment bundle for bcd_hex_display
interface bcd_hex_display_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [7*DIGITS-1:0]   hex_out;

  modport master (output start, output bin_in,
                  input busy, input done, input ovf, input hex_out);
  modport slave  (input start, input bin_in,
                  output busy, output done, output ovf, output hex_out);
endinterface

// File: rtl/bcd_hex_display.sv
// rtl/bcd_hex_display.sv - sequential double-dabble binary-to-BCD converter driving active-low HEX digits
// Optional leading-zero blanking: BCD_HEX_DISPLAY_LZ_BLANK_EN
module bcd_hex_display #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  bcd_hex_display_if.slave   bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int HEX_W = 7 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t              state;
  logic [BIN_W-1:0]    shift_q;
  logic [BCD_W-1:0]    bcd_q;
  logic [CNT_W-1:0]    count;
  logic                ovf_flag;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;
  logic [HEX_W-1:0]    hex_q;
  logic [BCD_W-1:0]    bcd_adj;
  logic [HEX_W-1:0]    hex_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h01;
      4'd1:    seg7 = 7'h4F;
      4'd2:    seg7 = 7'h12;
      4'd3:    seg7 = 7'h06;
      4'd4:    seg7 = 7'h4C;
      4'd5:    seg7 = 7'h24;
      4'd6:    seg7 = 7'h20;
      4'd7:    seg7 = 7'h0F;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h04;
      default: seg7 = 7'h30;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5)
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Scan from the top digit down so blanking stops at the first non-zero digit.
`ifdef BCD_HEX_DISPLAY_LZ_BLANK_EN
  logic seen;
  always_comb begin
    hex_next = '1;
    seen     = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (ovf_flag) begin
        hex_next[7*k +: 7] = 7'h30;
      end else begin
        if (bcd_q[4*k +: 4] != 4'd0)
          seen = 1'b1;
        if (!seen && k != 0)
          hex_next[7*k +: 7] = 7'h7F;
        else
          hex_next[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
      end
    end
  end
`else
  always_comb begin
    hex_next = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (ovf_flag)
        hex_next[7*k +: 7] = 7'h30;
      else
        hex_next[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift_q  <= '0;
      bcd_q    <= '0;
      count    <= '0;
      ovf_flag <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      hex_q    <= '1;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_q  <= bus.bin_in;
            bcd_q    <= '0;
            ovf_flag <= 1'b0;
            count    <= '0;
            busy_q   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // A one leaving the top digit means the value needs more digits than we have.
          {bcd_q, shift_q} <= {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
          ovf_flag         <= ovf_flag | bcd_adj[BCD_W-1];
          count            <= count + 1'b1;
          if (count == CNT_W'(BIN_W - 1))
            state <= LATCH;
        end
        LATCH: begin
          hex_q  <= hex_next;
          ovf_q  <= ovf_flag;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.hex_out = hex_q;
endmodule

// File: tb/tb_bcd_hex_display.sv
// tb/tb_bcd_hex_display.sv - scoreboard bench for bcd_hex_display conversions, latency, overflow and reset
module tb_bcd_hex_display;
  localparam int BIN_W  = 16;
  localparam int DIGITS = 4;
  localparam int HW     = 7 * DIGITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_hex_display_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();
  bcd_hex_display #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [HW:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] dseg(input int d);
    case (d)
      0: dseg = 7'h01; 1: dseg = 7'h4F; 2: dseg = 7'h12; 3: dseg = 7'h06;
      4: dseg = 7'h4C; 5: dseg = 7'h24; 6: dseg = 7'h20; 7: dseg = 7'h0F;
      8: dseg = 7'h00; default: dseg = 7'h04;
    endcase
  endfunction

  // Expected {ovf, hex_out} from plain decimal arithmetic.
  function automatic logic [HW:0] model(input int unsigned v);
    logic [HW-1:0] h;
    int unsigned lim = 1;
    int unsigned r;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    if (v >= lim) begin
      for (int k = 0; k < DIGITS; k++) h[7*k +: 7] = 7'h30;
      model = {1'b1, h};
    end else begin
      r = v;
      for (int k = 0; k < DIGITS; k++) begin
        h[7*k +: 7] = dseg(int'(r % 10));
`ifdef BCD_HEX_DISPLAY_LZ_BLANK_EN
        if (k > 0 && r == 0) h[7*k +: 7] = 7'h7F;
`endif
        r = r / 10;
      end
      model = {1'b0, h};
    end
  endfunction

  // Called at the negedge after the accept edge plus n0 further edges.
  task automatic wait_result(input string tag, input int n0);
    int n = n0;
    int bc = n0;
    logic [HW:0] e;
    while (!bus.done && n < 60) begin
      if (bus.busy) bc++;
      @(negedge clk);
      n++;
    end
    check({tag, "_done_edge"}, n, BIN_W + 1);
    check({tag, "_busy_cycles"}, bc, BIN_W + 1);
    check({tag, "_busy_low"}, bus.busy, 1'b0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_hex"}, bus.hex_out, e[HW-1:0]);
      check({tag, "_ovf"}, bus.ovf, e[HW]);
    end else begin
      check({tag, "_sb_empty"}, 1, 0);
    end
  endtask

  task automatic convert(input string tag, input int unsigned v);
    logic [HW-1:0] held;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = BIN_W'(v);
    @(posedge clk);
    sb.push_back(model(v));
    @(negedge clk);
    bus.start = 1'b0;
    wait_result(tag, 0);
    held = bus.hex_out;
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    repeat (3) @(negedge clk);
    check({tag, "_hold"}, bus.hex_out, held);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_hex", bus.hex_out, {HW{1'b1}});
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_ovf", bus.ovf, 1'b0);

    convert("v1234", 1234);

    // Back-to-back with start held; bin_in changes after the first accept.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = BIN_W'(9999);
    @(posedge clk);
    sb.push_back(model(9999));
    @(negedge clk);
    bus.bin_in = '0;
    wait_result("b2b_9999", 0);
    @(posedge clk);
    sb.push_back(model(0));
    @(negedge clk);
    bus.start = 1'b0;
    wait_result("b2b_0", 0);

    convert("v10000", 10000);
    convert("v65535", 65535);
    convert("v5", 5);

    // Start pulses and bin_in changes during a conversion are ignored.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = BIN_W'(42);
    @(posedge clk);
    sb.push_back(model(42));
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin_in = BIN_W'(8888);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = BIN_W'(31337);
    @(negedge clk);
    check("mid_busy", bus.busy, 1'b1);
    wait_result("v42", 3);

    for (int i = 0; i < 3; i++) convert("rand", $urandom_range(0, 65535));

    // Reset eight edges into a conversion.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = BIN_W'(4321);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_hex", bus.hex_out, {HW{1'b1}});
    check("abort_ovf", bus.ovf, 1'b0);
    check("abort_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen_done = 0;
      repeat (25) begin
        @(negedge clk);
        if (bus.done) seen_done++;
      end
      check("abort_no_done", seen_done, 0);
    end
    convert("after_rst_77", 77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
